// File: rtl/sum_stream_arbiter.sv
// sum_stream_arbiter: round-robin arbiter sharing one sum unit among N stream requesters.
// The granted lane feeds the unit through a one-element holding register; results return per lane.
module sum_stream_arbiter #(
   parameter int N     = 4,
   parameter int INT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req,
   input  logic [N*INT_W-1:0] s_data,
   input  logic [N-1:0]       s_valid,
   input  logic [N-1:0]       s_last,
   output logic [N-1:0]       s_ready,
   output logic [INT_W-1:0]   res_data,
   output logic [N-1:0]       res_valid,
   input  logic [N-1:0]       res_ready,
   output logic               u_in_valid,
   input  logic               u_in_ready,
   output logic [INT_W-1:0]   u_s,
   output logic               u_s_valid,
   input  logic               u_s_ready,
   input  logic [INT_W-1:0]   u_sum,
   input  logic               u_out_valid,
   output logic               u_out_ready
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic [2:0] {IDLE, START, STREAM, CLOSE, WAIT, RESP} state_t;
   state_t           state_q, state_d;
   logic [PW-1:0]    rr_q, rr_d, gnt_q, gnt_d, pick;
   logic [INT_W-1:0] hold_q, hold_d, res_q, res_d;
   logic             hv_q, hv_d, hl_q, hl_d;
   logic             lane_rdy, lane_fire, unit_fire;
   assign res_data = res_q;
   assign u_s      = hold_q;
   // lowest offset from rr_q wins, so the loop runs downward
   always_comb begin
      pick = rr_q;
      for (int k = N - 1; k >= 0; k--)
         if (req[(int'(rr_q) + k) % N]) pick = PW'((int'(rr_q) + k) % N);
   end
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      gnt_d       = gnt_q;
      hold_d      = hold_q;
      hv_d        = hv_q;
      hl_d        = hl_q;
      res_d       = res_q;
      s_ready     = '0;
      res_valid   = '0;
      u_in_valid  = 1'b0;
      u_s_valid   = 1'b0;
      u_out_ready = 1'b0;
      lane_rdy    = (!hv_q || u_s_ready) && !(hv_q && hl_q);
      lane_fire   = 1'b0;
      unit_fire   = 1'b0;
      case (state_q)
         IDLE: if (|req) begin
            gnt_d   = pick;
            state_d = START;
         end
         START: begin
            u_in_valid = 1'b1;
            hv_d       = 1'b0;
            if (u_in_ready) state_d = STREAM;
         end
         STREAM: begin
            s_ready[gnt_q] = lane_rdy;
            u_s_valid      = hv_q;
            unit_fire      = hv_q && u_s_ready;
            lane_fire      = s_valid[gnt_q] && lane_rdy;
            if (unit_fire) hv_d = 1'b0;
            if (lane_fire) begin
               hold_d = s_data[gnt_q*INT_W +: INT_W];
               hv_d   = 1'b1;
               hl_d   = s_last[gnt_q];
            end
            if (unit_fire && hl_q) state_d = CLOSE;
         end
         CLOSE: state_d = WAIT;
         WAIT: begin
            u_out_ready = 1'b1;
            if (u_out_valid) begin
               res_d   = u_sum;
               state_d = RESP;
            end
         end
         RESP: begin
            res_valid[gnt_q] = 1'b1;
            if (res_ready[gnt_q]) begin
               state_d = IDLE;
               rr_d    = (gnt_q == PW'(N - 1)) ? '0 : gnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         gnt_q   <= '0;
         hold_q  <= '0;
         hv_q    <= 1'b0;
         hl_q    <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
         hold_q  <= hold_d;
         hv_q    <= hv_d;
         hl_q    <= hl_d;
         res_q   <= res_d;
      end
endmodule
